axis_skid_slice: RTL
====================

# axis_skid_slice

Parametrised AXI-Stream register slice with tlast, tkeep and tuser sideband. It breaks timing on both the forward (tvalid/tdata) and backward (tready) paths of an AXI-S link. It sits between any AXI-S master and slave in the IO_interfaces/AXI/AXI-Stream hierarchy. A compile-time MODE selects a full skid buffer, forward-only register or wire bypass, and an optional performance-counter block can be compiled in.

## Interface
- DATA_WIDTH, 32: tdata width in bits; must be a multiple of 8 and ≥ 8.
- USER_WIDTH, 1: tuser width in bits, ≥ 1.
- MODE, 0: 0 = full skid (both paths registered), 1 = forward-only (data registered, tready combinational), 2 = bypass (all wires).
- COUNT_WIDTH, 32: width of the perf counters (used only with AXIS_SLICE_PERF_EN).
- Derived localparam KEEP_WIDTH = DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  upstream handshake.
- s_axis_tdata  in  DATA_WIDTH  upstream data.
- s_axis_tkeep  in  KEEP_WIDTH  upstream byte qualifiers.
- s_axis_tlast  in  1  upstream end of packet.
- s_axis_tuser  in  USER_WIDTH  upstream sideband.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  downstream handshake.
- m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser  out  as s-side  downstream payload.
- perf_clear  in  1  synchronous clear of all counters (PERF only).
- perf_beats, perf_packets, perf_stalls  out  COUNT_WIDTH each  counters (PERF only).

## Operation
- Payload = {tuser, tlast, tkeep, tdata}. It moves as one word and is never split.
- An s-side transfer occurs when s_tvalid & s_tready. An m-side transfer occurs when m_tvalid & m_tready.
- MODE 0 uses an output register (OREG) plus a skid register (SREG). FSM states:
  - EMPTY: OREG and SREG invalid.
  - BUSY: OREG valid, SREG invalid.
  - FULL: both valid.
- MODE 0 transitions:
  - EMPTY + s-xfer → BUSY; OREG ← s payload.
  - BUSY + s-xfer + m-xfer → BUSY; OREG ← s payload.
  - BUSY + s-xfer only → FULL; SREG ← s payload.
  - BUSY + m-xfer only → EMPTY.
  - FULL + m-xfer → BUSY; OREG ← SREG.
  - All other combinations: hold state and registers.
  - Unused state encoding → EMPTY.
- MODE 0 outputs:
  - s_axis_tready comes from a flop equal to (next_state != FULL). It is never a combinational function of m_axis_tready.
  - m_axis_tvalid = (state != EMPTY). m payload = OREG.
- MODE 1: a single OREG.
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (combinational).
  - OREG loads on each s-xfer. Valid clears on an m-xfer with no simultaneous s-xfer.
- MODE 2: all m outputs equal the s inputs, and s_axis_tready = m_axis_tready. No state.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated in any mode.
- Payload registers are not cleared on reset beyond the stated reset values. Only valid/state bits gate the output.

## Timing
- Latency, MODE 0 and MODE 1: 1 cycle from s-xfer to m_axis_tvalid on an empty slice.
- Latency, MODE 2: 0 cycles.
- Throughput: 1 beat/cycle sustained in MODE 0 and MODE 1 while m_axis_tready = 1.
- MODE 0 backpressure: s_axis_tready falls the cycle after m_axis_tready drops with OREG valid and an s-xfer occurring. At most one extra beat is absorbed into SREG.
- Reset while reset_n = 0:
  - m_axis_tvalid = 0, m payload = 0, FSM = EMPTY.
  - s_axis_tready = 0 in MODE 0 and rises on the first clk edge after release. MODE 1 and MODE 2 follow their combinational equations.
- Reset asserted mid-stream discards any beats held in OREG/SREG immediately (asynchronous).
- Once m_axis_tvalid is asserted it stays high with a stable payload until an m-xfer (AXI-S rule).

## Configuration
- Macro AXIS_SLICE_PERF_EN.
- When defined: perf_clear, perf_beats, perf_packets and perf_stalls exist.
  - perf_beats increments on each m-xfer.
  - perf_packets increments on each m-xfer with m_axis_tlast = 1.
  - perf_stalls increments each cycle m_axis_tvalid & ~m_axis_tready.
  - All counters saturate at 2^COUNT_WIDTH−1 and reset to 0 asynchronously.
  - perf_clear = 1 zeroes all counters on the next edge and takes priority over increment.
- When undefined: the ports and counter logic are absent. Datapath behaviour is identical.

## Test plan
- MODE 0, continuous valid, m_tready = 1, 8 beats tdata 0..7 → m beats 0..7 on consecutive cycles, first one cycle after the first s-xfer.
- MODE 0, m_tready held 0 for 3 cycles during a stream → exactly 2 beats accepted, then s_tready = 0; on release, beats appear in order with no loss or duplicate.
- MODE 0, random tvalid/tready (10k cycles, seeded) with tkeep/tlast/tuser varied → scoreboard matches and AXI-S stability assertions hold.
- MODE 1 and MODE 2 rerun of the previous scenario → same ordering. MODE 2 shows 0 latency; MODE 1 shows s_tready = m_tready whenever OREG is valid.
- reset_n pulsed low for 1 cycle while FULL → m_tvalid drops at once; after release s_tready = 1 on the first edge and the next beat in arrives intact.
- PERF on, COUNT_WIDTH = 4: 20 beats in 4 packets with 5 stall cycles → beats = 15 (saturated), packets = 4, stalls = 5; perf_clear → all 0 on the next cycle.

Source files
------------

// File: rtl/axis_skid_slice.sv
// axis_skid_slice: AXI-Stream register slice with tkeep/tlast/tuser (MODE 0 skid, 1 forward-only, 2 bypass).
// Optional saturating performance counters are compiled in when AXIS_SLICE_PERF_EN is defined.
module axis_skid_slice #(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned USER_WIDTH  = 1,
  parameter  int unsigned MODE        = 0,
  parameter  int unsigned COUNT_WIDTH = 32,
  localparam int unsigned KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef AXIS_SLICE_PERF_EN
  input  logic                   perf_clear,
  output logic [COUNT_WIDTH-1:0] perf_beats,
  output logic [COUNT_WIDTH-1:0] perf_packets,
  output logic [COUNT_WIDTH-1:0] perf_stalls,
`endif
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [USER_WIDTH-1:0]  m_axis_tuser
);

  localparam int unsigned PAYLOAD_WIDTH = USER_WIDTH + 1 + KEEP_WIDTH + DATA_WIDTH;

  // Elaboration-time parameter sanity.
  if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
    $error("axis_skid_slice: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if ((USER_WIDTH < 1) || (COUNT_WIDTH < 1) || (MODE > 2)) begin : g_bad_params
    $error("axis_skid_slice: USER_WIDTH/COUNT_WIDTH must be >= 1 and MODE <= 2");
  end

  logic [PAYLOAD_WIDTH-1:0] s_payload;
  logic [PAYLOAD_WIDTH-1:0] m_payload;

  assign s_payload = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_payload;

  if (MODE == 0) begin : g_skid
    typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [PAYLOAD_WIDTH-1:0] oreg;
    logic [PAYLOAD_WIDTH-1:0] sreg;
    logic                     s_ready_q;
    logic                     s_xfer;
    logic                     oreg_from_s;
    logic                     oreg_from_sreg;
    logic                     sreg_load;

    assign s_xfer        = s_axis_tvalid & s_ready_q;
    assign s_axis_tready = s_ready_q;
    assign m_payload     = oreg;

    // tready is registered from next_state so the backward path never sees m_axis_tready.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state     <= ST_EMPTY;
        s_ready_q <= 1'b0;
      end else begin
        state     <= state_nxt;
        s_ready_q <= (state_nxt != ST_FULL);
      end
    end

    always_comb begin
      state_nxt = ST_EMPTY;
      case (state)
        ST_EMPTY: state_nxt = s_xfer ? ST_BUSY : ST_EMPTY;
        ST_BUSY: begin
          if (s_xfer && !m_axis_tready)      state_nxt = ST_FULL;
          else if (!s_xfer && m_axis_tready) state_nxt = ST_EMPTY;
          else                               state_nxt = ST_BUSY;
        end
        ST_FULL:  state_nxt = m_axis_tready ? ST_BUSY : ST_FULL;
        default:  state_nxt = ST_EMPTY;
      endcase
    end

    always_comb begin
      m_axis_tvalid  = 1'b0;
      oreg_from_s    = 1'b0;
      oreg_from_sreg = 1'b0;
      sreg_load      = 1'b0;
      case (state)
        ST_EMPTY: oreg_from_s = s_xfer;
        ST_BUSY: begin
          m_axis_tvalid = 1'b1;
          oreg_from_s   = s_xfer & m_axis_tready;
          sreg_load     = s_xfer & ~m_axis_tready;
        end
        ST_FULL: begin
          m_axis_tvalid  = 1'b1;
          oreg_from_sreg = m_axis_tready;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            oreg <= '0;
      else if (oreg_from_s)    oreg <= s_payload;
      else if (oreg_from_sreg) oreg <= sreg;
    end

    // Skid register carries no reset; it is only observed through OREG after a FULL state.
    always_ff @(posedge clk) begin
      if (sreg_load) sreg <= s_payload;
    end
  end else if (MODE == 1) begin : g_fwd
    logic                     valid_q;
    logic [PAYLOAD_WIDTH-1:0] oreg;
    logic                     s_xfer;

    assign s_axis_tready = ~valid_q | m_axis_tready;
    assign s_xfer        = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = valid_q;
    assign m_payload     = oreg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        oreg    <= '0;
      end else if (s_xfer) begin
        valid_q <= 1'b1;
        oreg    <= s_payload;
      end else if (m_axis_tready) begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_bypass
    assign s_axis_tready = m_axis_tready;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_payload     = s_payload;
  end

`ifdef AXIS_SLICE_PERF_EN
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic perf_m_xfer;
  assign perf_m_xfer = m_axis_tvalid & m_axis_tready;

  // Saturating counters; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_beats   <= '0;
      perf_packets <= '0;
      perf_stalls  <= '0;
    end else if (perf_clear) begin
      perf_beats   <= '0;
      perf_packets <= '0;
      perf_stalls  <= '0;
    end else begin
      if (perf_m_xfer && (perf_beats != CNT_MAX))
        perf_beats <= perf_beats + COUNT_WIDTH'(1);
      if (perf_m_xfer && m_axis_tlast && (perf_packets != CNT_MAX))
        perf_packets <= perf_packets + COUNT_WIDTH'(1);
      if (m_axis_tvalid && !m_axis_tready && (perf_stalls != CNT_MAX))
        perf_stalls <= perf_stalls + COUNT_WIDTH'(1);
    end
  end
`endif

endmodule
